reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- Circular reorder buffer that allocates entries in program order at dispatch and collects results from the ALU and LSB broadcast buses.
- Presents the oldest completed entry each cycle to the commit decoder through rob_to_commit_en / instr_id / jump_en / jump_a.
- Retires that entry on the following clock edge.
- Flushes all contents when the commit decoder raises clear_branch.

Parameters:
- ROB_SIZE, 16, number of entries; must be a power of 2.
- ROB_W, 4, log2(ROB_SIZE); width of tags, head and tail.
- INSTR_ID_W, 6, width of the instruction id encoding.
- ADDR_W, 32, address width.
- DATA_W, 32, result data width.

Ports:
- clk_in  in  1  clock; all state updates on the rising edge.
- rst_n_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  global ready; when low, all state holds and rob_to_commit_en_out is 0.
- dispatch_en_in  in  1  allocate one entry at tail this cycle.
- dispatch_instr_id_in  in  INSTR_ID_W  instruction id of the new entry.
- dispatch_rd_in  in  5  destination register of the new entry.
- dispatch_tag_out  out  ROB_W  current tail index; the tag assigned to a dispatch this cycle.
- rob_full_out  out  1  count == ROB_SIZE.
- alu_en_in  in  1  ALU result valid.
- alu_tag_in  in  ROB_W  ALU result tag.
- alu_value_in  in  DATA_W  ALU result value.
- alu_jump_en_in  in  1  branch/jump taken and redirect required.
- alu_jump_a_in  in  ADDR_W  redirect target.
- lsb_en_in  in  1  LSB result valid; for stores, address/data resolved.
- lsb_tag_in  in  ROB_W  LSB result tag.
- lsb_value_in  in  DATA_W  LSB result value (load data).
- rob_to_commit_en_out  out  1  head entry is valid and ready; retires at the next edge.
- commit_instr_id_out  out  INSTR_ID_W  instruction id of the head entry.
- commit_jump_en_out  out  1  jump_en of the head entry.
- commit_jump_a_out  out  ADDR_W  jump target of the head entry.
- commit_rd_out  out  5  destination register of the head entry.
- commit_value_out  out  DATA_W  result value of the head entry.
- commit_tag_out  out  ROB_W  head index.
- clear_branch_in  in  1  flush request from the commit decoder.

Behaviour:
- Per-entry state: valid, ready, instr_id, rd, value, jump_en, jump_a. Global state: head, tail (ROB_W bits, wrap modulo ROB_SIZE), count (ROB_W+1 bits).
- Reset (rst_n_in low, asynchronous): head = tail = count = 0; all valid and ready bits = 0. All outputs read 0: rob_full_out = 0, rob_to_commit_en_out = 0, dispatch_tag_out = 0.
- Commit outputs are combinational from head-entry state:
  - rob_to_commit_en_out = rdy_in & valid[head] & ready[head].
  - The other commit_* outputs follow the head entry.
  - Whenever rob_to_commit_en_out = 0, commit_* outputs are 0.
- Retire: on an edge where rob_to_commit_en_out = 1, clear valid[head] and ready[head], head += 1, count -= 1.
- Dispatch: on an edge with rdy_in & dispatch_en_in & !rob_full_out:
  - Write entry[tail] with valid = 1, ready = 0, jump_en = 0.
  - tail += 1, count += 1.
  - Dispatch while full is ignored: no state change.
- Dispatch and retire on the same edge: count is unchanged. A full buffer does not accept a same-cycle dispatch, even though it retires on that edge.
- Writeback: on an edge with alu_en_in where valid[alu_tag_in] = 1:
  - ready = 1.
  - value, jump_en and jump_a are taken from the ALU inputs.
- LSB writeback is the same as ALU writeback, but jump_en is forced to 0.
- Writeback to an invalid tag is ignored.
- ALU and LSB writing the same tag on the same edge is illegal; the ALU write wins.
- Writeback latency: a result written at edge N makes the entry ready after edge N. If that entry is head, rob_to_commit_en_out rises in the cycle after edge N and the entry retires at edge N+1. There is no same-cycle bypass to commit.
- Writeback to the dispatch tag on the same edge as the dispatch is ignored; the entry is not yet valid.
- Flush: on an edge with rdy_in & clear_branch_in:
  - The head entry retires (clear_branch_in is only asserted with rob_to_commit_en_out).
  - All entries are invalidated.
  - head = tail = count = 0.
  - Any same-edge dispatch or writeback is discarded.
- rdy_in low: no dispatch, writeback, retire or flush takes effect; all registers hold.
- Wrap-around: head and tail roll from ROB_SIZE-1 to 0. Full versus empty is distinguished only by count.

Test Plan:
- Reset: assert rst_n_in low mid-run with 3 entries valid -> count = 0, rob_full_out = 0, rob_to_commit_en_out = 0, dispatch_tag_out = 0, all asynchronously, before the next edge.
- In-order commit: dispatch tags 0, 1, 2; ALU writes tag 2 (value 0x22), then tag 0 (value 0x11) -> tag 0 commits first with commit_value_out = 0x11. Tag 2 does not commit until tag 1 is written by the LSB with 0x33, then commits 1 then 2 on consecutive cycles.
- Full and wrap: dispatch 16 entries -> rob_full_out = 1; a 17th dispatch is ignored. Retire 1, then dispatch -> dispatch_tag_out = 0 (wrap), count = 16.
- Branch flush: tags 0..4 valid; ALU writes tag 0 with jump_en = 1, jump_a = 0x1000 -> next cycle commit_jump_en_out = 1 and commit_jump_a_out = 0x1000. Drive clear_branch_in = 1 with a same-edge dispatch -> after the edge count = 0, head = tail = 0, and the dispatch is dropped.
- Stall: hold rdy_in = 0 for 3 cycles with head ready and alu_en_in pulsing -> no retire, no state change, rob_to_commit_en_out = 0. When rdy_in returns, commit resumes from the same head.
- Conflict and stale writeback: ALU and LSB write the same tag with values 0xA and 0xB -> entry value = 0xA. A writeback to an invalid tag 7 -> no entry changes.

Source files
------------

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates entries in program order, collects
// ALU/LSB results, presents the oldest completed entry to the commit
// decoder, and flushes everything on a branch clear.
module reorder_buffer #(
    parameter int ROB_SIZE   = 16,
    parameter int ROB_W      = 4,
    parameter int INSTR_ID_W = 6,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  rdy_in,
    input  logic                  dispatch_en_in,
    input  logic [INSTR_ID_W-1:0] dispatch_instr_id_in,
    input  logic [4:0]            dispatch_rd_in,
    output logic [ROB_W-1:0]      dispatch_tag_out,
    output logic                  rob_full_out,
    input  logic                  alu_en_in,
    input  logic [ROB_W-1:0]      alu_tag_in,
    input  logic [DATA_W-1:0]     alu_value_in,
    input  logic                  alu_jump_en_in,
    input  logic [ADDR_W-1:0]     alu_jump_a_in,
    input  logic                  lsb_en_in,
    input  logic [ROB_W-1:0]      lsb_tag_in,
    input  logic [DATA_W-1:0]     lsb_value_in,
    output logic                  rob_to_commit_en_out,
    output logic [INSTR_ID_W-1:0] commit_instr_id_out,
    output logic                  commit_jump_en_out,
    output logic [ADDR_W-1:0]     commit_jump_a_out,
    output logic [4:0]            commit_rd_out,
    output logic [DATA_W-1:0]     commit_value_out,
    output logic [ROB_W-1:0]      commit_tag_out,
    input  logic                  clear_branch_in
);

    typedef struct packed {
        logic                  valid;
        logic                  ready;
        logic [INSTR_ID_W-1:0] instr_id;
        logic [4:0]            rd;
        logic [DATA_W-1:0]     value;
        logic                  jump_en;
        logic [ADDR_W-1:0]     jump_a;
    } entry_t;

    entry_t           entries_q [ROB_SIZE];
    entry_t           entries_d [ROB_SIZE];
    logic [ROB_W-1:0] head_q, head_d;
    logic [ROB_W-1:0] tail_q, tail_d;
    logic [ROB_W:0]   count_q, count_d;

    logic commit_en;
    logic dispatch_ok;

    // Head entry is offered for commit only when it is both allocated and complete.
    always_comb begin
        commit_en            = rdy_in & entries_q[head_q].valid & entries_q[head_q].ready;
        rob_to_commit_en_out = commit_en;
        commit_instr_id_out  = '0;
        commit_jump_en_out   = 1'b0;
        commit_jump_a_out    = '0;
        commit_rd_out        = '0;
        commit_value_out     = '0;
        commit_tag_out       = '0;
        if (commit_en) begin
            commit_instr_id_out = entries_q[head_q].instr_id;
            commit_jump_en_out  = entries_q[head_q].jump_en;
            commit_jump_a_out   = entries_q[head_q].jump_a;
            commit_rd_out       = entries_q[head_q].rd;
            commit_value_out    = entries_q[head_q].value;
            commit_tag_out      = head_q;
        end
    end

    assign rob_full_out     = (count_q == (ROB_W+1)'(ROB_SIZE));
    assign dispatch_tag_out = tail_q;
    assign dispatch_ok      = rdy_in & dispatch_en_in & ~rob_full_out;

    // Next state: writebacks first (ALU after LSB so it wins a tag clash),
    // then retire, then dispatch. A full buffer never dispatches, so the
    // retiring head and the dispatch slot cannot alias.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (rdy_in) begin
            if (clear_branch_in) begin
                for (int i = 0; i < ROB_SIZE; i++) begin
                    entries_d[i].valid = 1'b0;
                    entries_d[i].ready = 1'b0;
                end
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                if (lsb_en_in && entries_q[lsb_tag_in].valid) begin
                    entries_d[lsb_tag_in].ready   = 1'b1;
                    entries_d[lsb_tag_in].value   = lsb_value_in;
                    entries_d[lsb_tag_in].jump_en = 1'b0;
                    entries_d[lsb_tag_in].jump_a  = '0;
                end
                if (alu_en_in && entries_q[alu_tag_in].valid) begin
                    entries_d[alu_tag_in].ready   = 1'b1;
                    entries_d[alu_tag_in].value   = alu_value_in;
                    entries_d[alu_tag_in].jump_en = alu_jump_en_in;
                    entries_d[alu_tag_in].jump_a  = alu_jump_a_in;
                end
                if (commit_en) begin
                    entries_d[head_q].valid = 1'b0;
                    entries_d[head_q].ready = 1'b0;
                    head_d                  = head_q + ROB_W'(1);
                end
                if (dispatch_ok) begin
                    entries_d[tail_q].valid    = 1'b1;
                    entries_d[tail_q].ready    = 1'b0;
                    entries_d[tail_q].instr_id = dispatch_instr_id_in;
                    entries_d[tail_q].rd       = dispatch_rd_in;
                    entries_d[tail_q].value    = '0;
                    entries_d[tail_q].jump_en  = 1'b0;
                    entries_d[tail_q].jump_a   = '0;
                    tail_d                     = tail_q + ROB_W'(1);
                end
                count_d = count_q + (ROB_W+1)'(dispatch_ok) - (ROB_W+1)'(commit_en);
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < ROB_SIZE; i++) entries_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < ROB_SIZE; i++) entries_q[i] <= entries_d[i];
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed table, corner-case sequences and a
// randomized run, all checked against a queue-based program-order model.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy, disp_en, alu_en, alu_j, lsb_en, clr;
    logic [5:0]  disp_id;
    logic [4:0]  disp_rd;
    logic [3:0]  alu_tag, lsb_tag;
    logic [31:0] alu_val, alu_ja, lsb_val;
    logic [3:0]  dtag_o, ctag_o;
    logic        full_o, en_o, j_o;
    logic [5:0]  id_o;
    logic [31:0] ja_o, val_o;
    logic [4:0]  rd_o;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy),
        .dispatch_en_in(disp_en), .dispatch_instr_id_in(disp_id), .dispatch_rd_in(disp_rd),
        .dispatch_tag_out(dtag_o), .rob_full_out(full_o),
        .alu_en_in(alu_en), .alu_tag_in(alu_tag), .alu_value_in(alu_val),
        .alu_jump_en_in(alu_j), .alu_jump_a_in(alu_ja),
        .lsb_en_in(lsb_en), .lsb_tag_in(lsb_tag), .lsb_value_in(lsb_val),
        .rob_to_commit_en_out(en_o), .commit_instr_id_out(id_o),
        .commit_jump_en_out(j_o), .commit_jump_a_out(ja_o), .commit_rd_out(rd_o),
        .commit_value_out(val_o), .commit_tag_out(ctag_o), .clear_branch_in(clr)
    );

    // ---------------- reference model: in-flight instructions in program order
    typedef struct packed {
        logic [5:0]  id;
        logic [4:0]  rd;
        logic [31:0] value;
        logic        jen;
        logic [31:0] ja;
        logic        ready;
    } ment_t;

    ment_t mq[$];
    int    mhead = 0;

    function automatic bit m_en();
        return rdy && (mq.size() > 0) && mq[0].ready;
    endfunction

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        mq.delete();
        mhead = 0;
    endfunction

    // Apply one clock edge to the model using the currently driven inputs.
    function automatic void model_edge();
        int    n, k;
        bit    ret;
        ment_t e;
        if (!rdy) return;
        if (clr) begin
            model_reset();
            return;
        end
        n   = mq.size();
        ret = m_en();
        if (lsb_en && !(alu_en && alu_tag == lsb_tag)) begin
            k = (int'(lsb_tag) - mhead + 16) % 16;
            if (k < n) begin
                mq[k].ready = 1'b1; mq[k].value = lsb_val; mq[k].jen = 1'b0; mq[k].ja = '0;
            end
        end
        if (alu_en) begin
            k = (int'(alu_tag) - mhead + 16) % 16;
            if (k < n) begin
                mq[k].ready = 1'b1; mq[k].value = alu_val; mq[k].jen = alu_j; mq[k].ja = alu_ja;
            end
        end
        if (ret) begin
            void'(mq.pop_front());
            mhead = (mhead + 1) % 16;
        end
        if (disp_en && n < 16) begin
            e.id = disp_id; e.rd = disp_rd; e.value = '0; e.jen = 1'b0; e.ja = '0; e.ready = 1'b0;
            mq.push_back(e);
        end
    endfunction

    function automatic void check_model();
        bit    en;
        ment_t h;
        en = m_en();
        h  = '0;
        if (en) h = mq[0];
        chk("m_commit_en",   64'(en_o),   64'(en));
        chk("m_instr_id",    64'(id_o),   64'(h.id));
        chk("m_jump_en",     64'(j_o),    64'(h.jen));
        chk("m_jump_a",      64'(ja_o),   64'(h.ja));
        chk("m_rd",          64'(rd_o),   64'(h.rd));
        chk("m_value",       64'(val_o),  64'(h.value));
        chk("m_commit_tag",  64'(ctag_o), en ? 64'(mhead) : 64'd0);
        chk("m_full",        64'(full_o), 64'(mq.size() == 16));
        chk("m_dispatch_tag",64'(dtag_o), 64'((mhead + mq.size()) % 16));
    endfunction

    // ---------------- stimulus helpers
    task automatic idle();
        rdy = 1'b1; disp_en = 1'b0; disp_id = '0; disp_rd = '0;
        alu_en = 1'b0; alu_tag = '0; alu_val = '0; alu_j = 1'b0; alu_ja = '0;
        lsb_en = 1'b0; lsb_tag = '0; lsb_val = '0; clr = 1'b0;
    endtask

    // Entered at posedge+1; checks before the edge, advances model at the edge.
    task automatic cyc();
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input logic [5:0] id);
        idle(); disp_en = 1'b1; disp_id = id; disp_rd = 5'(id); cyc();
    endtask

    task automatic alu_wr(input logic [3:0] tag, input logic [31:0] v);
        idle(); alu_en = 1'b1; alu_tag = tag; alu_val = v; cyc();
    endtask

    // ---------------- directed table: in-order commit
    typedef struct {
        bit          disp;
        logic [5:0]  id;
        bit          alu;
        logic [3:0]  atag;
        logic [31:0] aval;
        bit          lsb;
        logic [3:0]  ltag;
        logic [31:0] lval;
        bit          e_en;
        logic [5:0]  e_id;
        logic [31:0] e_val;
        logic [3:0]  e_ctag;
        logic [3:0]  e_dtag;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1, 6'd1, 0, 4'd0, 32'h0,  0, 4'd0, 32'h0,  0, 6'd0, 32'h0,  4'd0, 4'd0};
        tbl[1]  = '{1, 6'd2, 0, 4'd0, 32'h0,  0, 4'd0, 32'h0,  0, 6'd0, 32'h0,  4'd0, 4'd1};
        tbl[2]  = '{1, 6'd3, 0, 4'd0, 32'h0,  0, 4'd0, 32'h0,  0, 6'd0, 32'h0,  4'd0, 4'd2};
        tbl[3]  = '{0, 6'd0, 1, 4'd2, 32'h22, 0, 4'd0, 32'h0,  0, 6'd0, 32'h0,  4'd0, 4'd3};
        tbl[4]  = '{0, 6'd0, 1, 4'd0, 32'h11, 0, 4'd0, 32'h0,  0, 6'd0, 32'h0,  4'd0, 4'd3};
        tbl[5]  = '{0, 6'd0, 0, 4'd0, 32'h0,  0, 4'd0, 32'h0,  1, 6'd1, 32'h11, 4'd0, 4'd3};
        tbl[6]  = '{0, 6'd0, 0, 4'd0, 32'h0,  0, 4'd0, 32'h0,  0, 6'd0, 32'h0,  4'd0, 4'd3};
        tbl[7]  = '{0, 6'd0, 0, 4'd0, 32'h0,  1, 4'd1, 32'h33, 0, 6'd0, 32'h0,  4'd0, 4'd3};
        tbl[8]  = '{0, 6'd0, 0, 4'd0, 32'h0,  0, 4'd0, 32'h0,  1, 6'd2, 32'h33, 4'd1, 4'd3};
        tbl[9]  = '{0, 6'd0, 0, 4'd0, 32'h0,  0, 4'd0, 32'h0,  1, 6'd3, 32'h22, 4'd2, 4'd3};
        tbl[10] = '{0, 6'd0, 0, 4'd0, 32'h0,  0, 4'd0, 32'h0,  0, 6'd0, 32'h0,  4'd0, 4'd3};

        // power-on reset
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_commit_en",   64'(en_o),   64'd0);
        chk("rst_full",        64'(full_o), 64'd0);
        chk("rst_dispatch_tag",64'(dtag_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int r = 0; r < 11; r++) begin
            idle();
            disp_en = tbl[r].disp; disp_id = tbl[r].id; disp_rd = 5'(tbl[r].id);
            alu_en = tbl[r].alu; alu_tag = tbl[r].atag; alu_val = tbl[r].aval;
            lsb_en = tbl[r].lsb; lsb_tag = tbl[r].ltag; lsb_val = tbl[r].lval;
            #1;
            chk($sformatf("tbl%0d_en", r),   64'(en_o),   64'(tbl[r].e_en));
            chk($sformatf("tbl%0d_id", r),   64'(id_o),   64'(tbl[r].e_id));
            chk($sformatf("tbl%0d_val", r),  64'(val_o),  64'(tbl[r].e_val));
            chk($sformatf("tbl%0d_ctag", r), 64'(ctag_o), 64'(tbl[r].e_ctag));
            chk($sformatf("tbl%0d_dtag", r), 64'(dtag_o), 64'(tbl[r].e_dtag));
            cyc();
        end

        // asynchronous reset mid-run with three entries valid, head ready
        dispatch(6'h20); dispatch(6'h21); dispatch(6'h22);
        alu_wr(4'd3, 32'h5A);
        idle();
        #1;
        chk("pre_rst_en", 64'(en_o), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_en",    64'(en_o),   64'd0);
        chk("arst_full",  64'(full_o), 64'd0);
        chk("arst_dtag",  64'(dtag_o), 64'd0);
        chk("arst_value", 64'(val_o),  64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // full and wrap
        for (int i = 0; i < 16; i++) dispatch(6'(i));
        chk("full16", 64'(full_o), 64'd1);
        dispatch(6'h3F);                       // 17th, ignored
        chk("full17_dtag", 64'(dtag_o), 64'd0);
        alu_wr(4'd0, 32'h5);
        idle(); disp_en = 1'b1; disp_id = 6'h3E;   // retire edge: dispatch refused while full
        #1;
        chk("full_retire_en", 64'(en_o), 64'd1);
        cyc();
        chk("after_retire_full", 64'(full_o), 64'd0);
        chk("wrap_dtag",         64'(dtag_o), 64'd0);
        cyc();                                 // dispatch into wrapped tag 0
        chk("wrap_full", 64'(full_o), 64'd1);
        chk("wrap_tail", 64'(dtag_o), 64'd1);

        // branch flush with same-edge dispatch and writeback
        do_reset();
        for (int i = 0; i < 5; i++) dispatch(6'(8'h10 + i));
        idle(); alu_en = 1'b1; alu_tag = 4'd0; alu_val = 32'h77; alu_j = 1'b1; alu_ja = 32'h1000;
        cyc();
        idle(); clr = 1'b1; disp_en = 1'b1; disp_id = 6'h3F;
        alu_en = 1'b1; alu_tag = 4'd1; alu_val = 32'h12;
        #1;
        chk("flush_jump_en", 64'(j_o),  64'd1);
        chk("flush_jump_a",  64'(ja_o), 64'h1000);
        chk("flush_en",      64'(en_o), 64'd1);
        cyc();
        idle();
        #1;
        chk("post_flush_en",   64'(en_o),   64'd0);
        chk("post_flush_full", 64'(full_o), 64'd0);
        chk("post_flush_dtag", 64'(dtag_o), 64'd0);
        alu_wr(4'd1, 32'hBAD);
        dispatch(6'h2A);
        alu_wr(4'd0, 32'h99);
        idle();
        #1;
        chk("refill_en",  64'(en_o),   64'd1);
        chk("refill_val", 64'(val_o),  64'h99);
        chk("refill_id",  64'(id_o),   64'h2A);
        chk("refill_tag", 64'(ctag_o), 64'd0);
        cyc();

        // stall: rdy low freezes everything
        do_reset();
        dispatch(6'h30); dispatch(6'h31);
        alu_wr(4'd0, 32'h44);
        for (int i = 0; i < 3; i++) begin
            idle(); rdy = 1'b0; disp_en = 1'b1; disp_id = 6'h3A;
            alu_en = (i % 2 == 0); alu_tag = 4'd1; alu_val = 32'h55;
            #1;
            chk("stall_en", 64'(en_o), 64'd0);
            cyc();
        end
        idle();
        #1;
        chk("resume_en",   64'(en_o),   64'd1);
        chk("resume_tag",  64'(ctag_o), 64'd0);
        chk("resume_val",  64'(val_o),  64'h44);
        chk("resume_dtag", 64'(dtag_o), 64'd2);
        cyc();
        chk("stall_wb_ignored", 64'(en_o), 64'd0);

        // ALU/LSB clash on one tag, then writeback to an invalid tag
        do_reset();
        dispatch(6'h05);
        idle(); alu_en = 1'b1; alu_tag = 4'd0; alu_val = 32'hA;
        lsb_en = 1'b1; lsb_tag = 4'd0; lsb_val = 32'hB;
        cyc();
        idle(); alu_en = 1'b1; alu_tag = 4'd7; alu_val = 32'hDEAD;
        #1;
        chk("clash_val", 64'(val_o), 64'hA);
        cyc();
        for (int i = 0; i < 8; i++) dispatch(6'(i));
        cyc();

        // randomized run against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            idle();
            rdy     = ($urandom % 8) != 0;
            disp_en = 1'($urandom % 2);
            disp_id = 6'($urandom);
            disp_rd = 5'($urandom);
            alu_en  = ($urandom % 4) != 0;
            alu_tag = 4'(mhead + int'($urandom_range(mq.size() + 1, 0)));
            alu_val = $urandom;
            alu_j   = 1'($urandom);
            alu_ja  = $urandom;
            lsb_en  = 1'($urandom % 2);
            lsb_tag = 4'(mhead + int'($urandom_range(mq.size() + 1, 0)));
            lsb_val = $urandom;
            clr     = m_en() && (($urandom % 32) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
